// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_slot.sv
// One-entry {instr, pc, valid} holding register used while IF/ID is stalled.
module if_skid_slot
  import if_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   unload,
  input  logic   clear,
  input  fetch_t din,
  output fetch_t dout,
  output logic   valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, runs req/ack to instruction memory, presents
// {instr, pc, valid} to IF/ID with a skid slot for stalls and redirect draining.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] ir_out,
  output logic [31:0] pc_out
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  fetch_t      out_q, out_d;
  logic        vld_q, vld_d;

  logic   skid_load, skid_unload, skid_clear;
  fetch_t skid_dout;
  logic   skid_valid;
  logic   ack;
  logic   consumed;
  logic   out_free;

  assign imem_req  = (state_q == S_WAIT) || (state_q == S_DRAIN);
  // A draining request must keep its original address until it is acked.
  assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign ack       = imem_req && imem_ack;
  assign consumed  = vld_q && !stall;
  assign out_free  = !vld_q || !stall;

  assign if_valid = vld_q;
  assign ir_out   = vld_q ? out_q.instr : NOP_WORD;
  assign pc_out   = out_q.pc;

  if_skid_slot u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    ('{instr: imem_rdata, pc: pc_q}),
    .dout   (skid_dout),
    .valid  (skid_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      out_q        <= '{instr: NOP_WORD, pc: 32'h0};
      vld_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      out_q        <= out_d;
      vld_q        <= vld_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    out_d        = out_q;
    vld_d        = vld_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;

    if (redirect) begin
      pc_d       = align_pc(redirect_pc);
      vld_d      = 1'b0;
      skid_clear = 1'b1;
      // An ack on this edge retires the outstanding request, so no drain is needed.
      if (imem_req && !ack) begin
        state_d = S_DRAIN;
        if (state_q == S_WAIT) drain_addr_d = pc_q;
      end else begin
        state_d = S_WAIT;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: begin
          if (ack) begin
            pc_d = pc_q + PC_INC;
            if (out_free) begin
              out_d = '{instr: imem_rdata, pc: pc_q};
              vld_d = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = S_FULL;
            end
          end else if (consumed) begin
            vld_d = 1'b0;
          end
        end
        S_FULL: begin
          if (!stall) begin
            out_d       = skid_dout;
            vld_d       = skid_valid;
            skid_unload = 1'b1;
            state_d     = S_WAIT;
          end
        end
        S_DRAIN: if (ack) state_d = S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector tables, async-reset sequence, and a
// randomized run checked against a program-order stream model.
module tb_if_fetch_unit;

  localparam logic [31:0] MASK = 32'hFFFF_0000;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        if_valid;
  logic [31:0] ir_out;
  logic [31:0] pc_out;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model state
  int cnt = 0;
  int lat = 0;
  int lat_fixed = 0;
  bit lat_rand = 0;

  // stream reference model state
  bit          model_on = 0;
  logic [31:0] exp_pc;
  logic [31:0] fetch_pc;
  bit          stale;
  int          consumed;

  if_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (ack),
    .imem_rdata  (rdata),
    .if_valid    (if_valid),
    .ir_out      (ir_out),
    .pc_out      (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    int          lat;
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pcx;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit rst, int l, bit s, bit r, logic [31:0] rpc,
                              bit req, logic [31:0] addr, bit vld, logic [31:0] pcx);
    vec_t v;
    v.rst = rst; v.lat = l; v.stall = s; v.redir = r; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.pcx = pcx;
    return v;
  endfunction

  // Spec-level model: consumed instructions form a +4 sequence restarting at each
  // redirect target; accepted non-stale fetches walk the same sequence.
  task automatic model_edge();
    if (redirect) begin
      exp_pc   = {redirect_pc[31:2], 2'b00};
      fetch_pc = exp_pc;
      stale    = imem_req && !ack;
    end else begin
      if (imem_req && ack) begin
        if (stale) stale = 0;
        else begin
          chk("rnd_fetch_addr", imem_addr, fetch_pc);
          fetch_pc = fetch_pc + 32'd4;
        end
      end
      if (if_valid && !stall) begin
        chk("rnd_pc_out", pc_out, exp_pc);
        chk("rnd_ir_out", ir_out, exp_pc ^ MASK);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
    end
  endtask

  // Called at a negedge with inputs set; advances one clock to the next negedge.
  task automatic step();
    bit pre_req, pre_ack;
    ack     = imem_req && (cnt >= lat);
    rdata   = imem_addr ^ MASK;
    pre_req = imem_req;
    pre_ack = ack;
    if (model_on) model_edge();
    @(posedge clk);
    if (pre_req && !pre_ack) cnt++;
    else begin
      cnt = 0;
      lat = lat_rand ? int'($urandom_range(0, 2)) : lat_fixed;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; ack = 1'b0;
    lat_fixed = l; lat = l; cnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // zero-wait stream, 4-cycle stall with skid, redirect coincident with ack
    tab.push_back(mk(1, 0, 0, 0, 0,            0, 0,            0, 32'h0));
    tab.push_back(mk(0, 0, 0, 0, 0,            1, 32'h3000,     0, 32'h0));
    tab.push_back(mk(0, 0, 0, 0, 0,            1, 32'h3004,     1, 32'h3000));
    tab.push_back(mk(0, 0, 1, 0, 0,            1, 32'h3008,     1, 32'h3004));
    tab.push_back(mk(0, 0, 1, 0, 0,            0, 0,            1, 32'h3004));
    tab.push_back(mk(0, 0, 1, 0, 0,            0, 0,            1, 32'h3004));
    tab.push_back(mk(0, 0, 1, 0, 0,            0, 0,            1, 32'h3004));
    tab.push_back(mk(0, 0, 0, 0, 0,            0, 0,            1, 32'h3004));
    tab.push_back(mk(0, 0, 0, 0, 0,            1, 32'h300C,     1, 32'h3008));
    tab.push_back(mk(0, 0, 0, 0, 0,            1, 32'h3010,     1, 32'h300C));
    tab.push_back(mk(0, 0, 0, 1, 32'h3203,     1, 32'h3014,     1, 32'h3010));
    tab.push_back(mk(0, 0, 0, 0, 0,            1, 32'h3200,     0, 32'h3010));
    tab.push_back(mk(0, 0, 0, 0, 0,            1, 32'h3204,     1, 32'h3200));
    // 3-cycle memory, single-cycle valid pulses, redirect while pending -> drain
    tab.push_back(mk(1, 2, 0, 0, 0,            0, 0,            0, 32'h0));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3000,     0, 32'h0));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3000,     0, 32'h0));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3000,     0, 32'h0));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3004,     1, 32'h3000));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3004,     0, 32'h3000));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3004,     0, 32'h3000));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3008,     1, 32'h3004));
    tab.push_back(mk(0, 2, 0, 1, 32'h3100,     1, 32'h3008,     0, 32'h3004));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3008,     0, 32'h3004));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3100,     0, 32'h3004));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3100,     0, 32'h3004));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3100,     0, 32'h3004));
    tab.push_back(mk(0, 2, 0, 0, 0,            1, 32'h3104,     1, 32'h3100));

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].rst) do_reset(tab[i].lat);
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, tab[i].req});
      if (tab[i].req) chk($sformatf("v%0d_addr", i), imem_addr, tab[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, tab[i].vld});
      chk($sformatf("v%0d_pc_out", i), pc_out, tab[i].pcx);
      chk($sformatf("v%0d_ir_out", i), ir_out, tab[i].vld ? (tab[i].pcx ^ MASK) : NOP);
      stall       = tab[i].stall;
      redirect    = tab[i].redir;
      redirect_pc = tab[i].rpc;
      step();
    end
    stall = 1'b0; redirect = 1'b0;

    // asynchronous reset in the middle of a WAIT at pc 3010
    do_reset(0);
    for (int i = 0; i < 5; i++) step();
    chk("ar_pre_addr", imem_addr, 32'h3010);
    chk("ar_pre_valid", {31'b0, if_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_req", {31'b0, imem_req}, 32'd0);
    chk("ar_valid", {31'b0, if_valid}, 32'd0);
    chk("ar_ir", ir_out, NOP);
    chk("ar_pc_out", pc_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    step();
    chk("ar_restart_req", {31'b0, imem_req}, 32'd1);
    chk("ar_restart_addr", imem_addr, 32'h3000);

    // randomized run against the stream model
    do_reset(0);
    lat_rand = 1;
    exp_pc = 32'h3000; fetch_pc = 32'h3000; stale = 0; consumed = 0;
    model_on = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!if_valid) chk("rnd_nop", ir_out, NOP);
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else redirect_pc = 32'h3000 + 32'($urandom_range(0, 4095));
      step();
    end
    model_on = 0;
    chk("rnd_progress", {31'b0, consumed > 300}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
